hazard_stall_unit: RTL and testbench

- Pipeline sequencing block for the 5-stage MIPS core. It sits beside the main opcode controller and drives the pipeline-register and PC write enables and the flush controls.
- Detects load-use hazards, branch and jump redirects, and data-memory wait states. Generates the EX-stage forwarding selects.
- Contains a small FSM that freezes the whole pipeline while data memory is busy. Also provides a sticky timeout error and a saturating stall counter.

---
 rtl/hazard_stall_unit.sv | 163 ++++++++++++++++
 tb/tb_hazard_stall_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Pipeline sequencing for the 5-stage MIPS core: load-use/branch/jump hazards,
// data-memory wait freeze with timeout, EX forwarding selects and a stall counter.
module hazard_stall_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_MEM_WAIT = 2'b01;
  localparam logic [1:0] ST_ERROR    = 2'b10;
  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic mem_stall;
  logic in_error;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] m_rd, input logic m_we,
                                         input logic [4:0] w_rd, input logic w_we);
    logic [1:0] sel;
    sel = 2'b00;
    if (m_we && (m_rd != 5'd0) && (m_rd == src)) begin
      sel = 2'b10;
    end else if (w_we && (w_rd != 5'd0) && (w_rd == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    load_use = ex_memtoreg && ex_regwrite && (ex_rd != 5'd0) &&
               ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));
    in_error  = (state_q != ST_RUN) && (state_q != ST_MEM_WAIT);
    // The ready cycle of a pending access is not a stall; normal hazard rules apply.
    mem_stall = !mem_ready && ((state_q == ST_MEM_WAIT) || ((state_q == ST_RUN) && mem_req));
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (!rst_n || in_error || mem_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst_n) begin
      fwd_a = fwd_sel(ex_rs, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
      fwd_b = fwd_sel(ex_rt, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_d >= TIMEOUT_LIM) begin
            state_d       = ST_ERROR;
            mem_timeout_d = 1'b1;
          end
        end
      end
      default: begin
        // ERROR (and the unused encoding) is only left through reset.
        state_d = ST_ERROR;
      end
    endcase
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign state       = state_q;
  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed vectors push expected
// outputs, a negedge monitor pops and compares them.
module tb_hazard_stall_unit;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 4;

  logic clk;
  logic rst_n;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs, id_uses_rt, id_jump;
  logic ex_regwrite, ex_memtoreg, ex_branch_taken;
  logic mem_regwrite, mem_req, mem_ready, wb_regwrite;
  logic pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic ifid_flush, idex_flush;
  logic [1:0] fwd_a, fwd_b, state;
  logic mem_timeout;
  logic [TB_CNT_W-1:0] stall_cnt;

  typedef struct {
    string               name;
    logic [4:0]          en;
    logic [1:0]          fl;
    logic [1:0]          fa;
    logic [1:0]          fb;
    logic [1:0]          st;
    logic                to;
    logic [TB_CNT_W-1:0] cnt;
  } exp_t;

  exp_t expq[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  hazard_stall_unit #(.MEM_TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .memwb_write(memwb_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input string field,
                             input logic [7:0] act, input logic [7:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s.%s: got %0h, expected %0h", name, field, act, exp);
    end
  endtask

  // Monitor: every vector holds its outputs steady until the negedge.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      checkOutput(e.name, "enables", {3'b0, pc_write, ifid_write, idex_write, exmem_write, memwb_write}, {3'b0, e.en});
      checkOutput(e.name, "flushes", {6'b0, ifid_flush, idex_flush}, {6'b0, e.fl});
      checkOutput(e.name, "fwd_a", {6'b0, fwd_a}, {6'b0, e.fa});
      checkOutput(e.name, "fwd_b", {6'b0, fwd_b}, {6'b0, e.fb});
      checkOutput(e.name, "state", {6'b0, state}, {6'b0, e.st});
      checkOutput(e.name, "mem_timeout", {7'b0, mem_timeout}, {7'b0, e.to});
      checkOutput(e.name, "stall_cnt", {4'b0, stall_cnt}, {4'b0, e.cnt});
    end
  end

  task automatic clearInputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0;
    ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0;
    ex_regwrite = 1'b0; ex_memtoreg = 1'b0; ex_branch_taken = 1'b0;
    mem_rd = 5'd0; mem_regwrite = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    wb_rd = 5'd0; wb_regwrite = 1'b0;
  endtask

  task automatic setLoadUse(input logic [4:0] rd);
    ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_rd = rd; id_rs = rd; id_uses_rs = 1'b1;
  endtask

  // Inputs are already set; record what the DUT must show this cycle, then advance.
  task automatic applyStimulus(input string name, input logic [4:0] en, input logic [1:0] fl,
                               input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] st,
                               input logic to, input logic [TB_CNT_W-1:0] cnt);
    exp_t e;
    e.name = name; e.en = en; e.fl = fl; e.fa = fa; e.fb = fb;
    e.st = st; e.to = to; e.cnt = cnt;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    logic [1:0] st_k;
    rst_n = 1'b0;
    clearInputs();
    @(posedge clk); #1;

    // Reset gates enables and forwarding even with a forwarding match present.
    ex_rs = 5'd5; mem_rd = 5'd5; mem_regwrite = 1'b1;
    applyStimulus("reset", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'd0);
    rst_n = 1'b1; clearInputs();
    applyStimulus("idle", 5'b11111, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'd0);

    setLoadUse(5'd8);
    applyStimulus("load_use", 5'b00111, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 4'd0);
    clearInputs();
    applyStimulus("after_lu", 5'b11111, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'd1);
    ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b0;
    applyStimulus("lu_rt_unused", 5'b11111, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'd1);
    clearInputs();
    ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    applyStimulus("lu_r0", 5'b11111, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'd1);
    clearInputs();
    setLoadUse(5'd8); ex_branch_taken = 1'b1;
    applyStimulus("branch_over_lu", 5'b11111, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 4'd1);
    clearInputs();
    id_jump = 1'b1;
    applyStimulus("jump", 5'b11111, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 4'd1);
    setLoadUse(5'd12);
    applyStimulus("lu_over_jump", 5'b00111, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 4'd1);
    clearInputs();

    mem_rd = 5'd5; wb_rd = 5'd5; mem_regwrite = 1'b1; wb_regwrite = 1'b1; ex_rs = 5'd5; ex_rt = 5'd5;
    applyStimulus("fwd_exmem", 5'b11111, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 4'd2);
    mem_regwrite = 1'b0;
    applyStimulus("fwd_memwb", 5'b11111, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 4'd2);
    mem_regwrite = 1'b1; ex_rs = 5'd0; ex_rt = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    applyStimulus("fwd_r0", 5'b11111, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'd2);
    ex_rs = 5'd5; ex_rt = 5'd6; mem_rd = 5'd6; wb_rd = 5'd5;
    applyStimulus("fwd_mixed", 5'b11111, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 4'd2);
    clearInputs();

    mem_req = 1'b1; mem_ready = 1'b0;
    applyStimulus("wait_run", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'd2);
    applyStimulus("wait_1", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 4'd3);
    applyStimulus("wait_2", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 4'd4);
    mem_ready = 1'b1; ex_branch_taken = 1'b1;
    applyStimulus("wait_ready_branch", 5'b11111, 2'b11, 2'b00, 2'b00, 2'b01, 1'b0, 4'd5);
    clearInputs();
    applyStimulus("wait_back_run", 5'b11111, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'd5);
    mem_req = 1'b1; mem_ready = 1'b1;
    applyStimulus("zero_wait", 5'b11111, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'd5);

    mem_ready = 1'b0;
    applyStimulus("to_run", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'd5);
    applyStimulus("to_w1", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 4'd6);
    applyStimulus("to_w2", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 4'd7);
    applyStimulus("to_w3", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 4'd8);
    mem_ready = 1'b1;
    applyStimulus("err_ready", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1, 4'd9);
    ex_branch_taken = 1'b1; ex_rs = 5'd3; mem_rd = 5'd3; mem_regwrite = 1'b1;
    applyStimulus("err_branch_fwd", 5'b00000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b1, 4'd10);
    rst_n = 1'b0;
    applyStimulus("err_reset", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'd0);
    rst_n = 1'b1; clearInputs();
    applyStimulus("post_reset", 5'b11111, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'd0);

    mem_req = 1'b1;
    applyStimulus("ar_run", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'd0);
    applyStimulus("ar_w1", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 4'd1);
    #2 rst_n = 1'b0;
    applyStimulus("async_reset", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'd0);
    rst_n = 1'b1;

    // Hold the access forever: RUN, three waits, then ERROR counting until saturation.
    for (k = 0; k < 20; k++) begin
      st_k = (k == 0) ? 2'b00 : ((k < 4) ? 2'b01 : 2'b10);
      applyStimulus($sformatf("sat_%0d", k), 5'b00000, 2'b00, 2'b00, 2'b00, st_k,
                    (k >= 4), (k < 15) ? 4'(k) : 4'd15);
    end
    clearInputs();

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    if (expq.size() > 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
